// File: rtl/mips_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : mips_pkg                                                        |
// | Purpose  : Shared MIPS encoding constants. The descriptor kind enumeration  |
// |            is used by the encoder. The opcode and funct constants are also |
// |            used by the main control decoder.                               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package mips_pkg;

  // Descriptor kinds. Codes 9..15 are illegal.
  typedef enum logic [3:0] {
    KIND_ADD  = 4'd0,
    KIND_SUB  = 4'd1,
    KIND_AND  = 4'd2,
    KIND_OR   = 4'd3,
    KIND_SLT  = 4'd4,
    KIND_LW   = 4'd5,
    KIND_SW   = 4'd6,
    KIND_BEQ  = 4'd7,
    KIND_ADDI = 4'd8
  } kind_e;

  // Primary opcodes (instr[31:26]).
  localparam logic [5:0] R_TYPE = 6'b000000;
  localparam logic [5:0] LW     = 6'b100011;
  localparam logic [5:0] SW     = 6'b101011;
  localparam logic [5:0] BEQ    = 6'b000100;
  localparam logic [5:0] ADDI   = 6'b001000;

  // R-type function codes (instr[5:0]).
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/mips_instr_pack.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mips_instr_pack                                                 |
// | Purpose  : Purely combinational packer. It turns one symbolic descriptor   |
// |            into a 32-bit MIPS word.                                        |
// | Ports    : kind[3:0], rs/rt/rd[4:0], imm[15:0] in;                         |
// |            instr[31:0] out (0 when illegal), legal out                     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mips_instr_pack
  import mips_pkg::*;
(
  input  logic [3:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  output logic [31:0] instr,
  output logic        legal
);

  always_comb begin
    instr = '0;
    legal = 1'b1;
    case (kind)
      KIND_ADD:  instr = {R_TYPE, rs, rt, rd, 5'b00000, FUNCT_ADD};
      KIND_SUB:  instr = {R_TYPE, rs, rt, rd, 5'b00000, FUNCT_SUB};
      KIND_AND:  instr = {R_TYPE, rs, rt, rd, 5'b00000, FUNCT_AND};
      KIND_OR:   instr = {R_TYPE, rs, rt, rd, 5'b00000, FUNCT_OR};
      KIND_SLT:  instr = {R_TYPE, rs, rt, rd, 5'b00000, FUNCT_SLT};
      // For I-type instructions rd is ignored and the immediate is passed verbatim.
      KIND_LW:   instr = {LW,   rs, rt, imm};
      KIND_SW:   instr = {SW,   rs, rt, imm};
      KIND_BEQ:  instr = {BEQ,  rs, rt, imm};
      KIND_ADDI: instr = {ADDI, rs, rt, imm};
      default:   legal = 1'b0;
    endcase
  end

endmodule : mips_instr_pack
`default_nettype wire

// File: rtl/mips_instr_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mips_instr_encoder                                              |
// | Purpose  : Streaming encoder. Each accepted descriptor is packed into a    |
// |            32-bit word. The word is presented with an auto-incrementing    |
// |            instruction-memory write address.                               |
// | Ports    : clk, rst_n (async, active-low), start pulse;                    |
// |            in_valid/in_ready + in_kind/in_rs/in_rt/in_rd/in_imm descriptor;|
// |            out_valid/out_ready + out_instr/out_addr word;                  |
// |            count (words since start), err (sticky illegal), full           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mips_instr_encoder
  import mips_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic [ADDR_W:0]   count,
  output logic              err,
  output logic              full
);

  // Number of words the memory holds (2^ADDR_W).
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FULL = 2'd2
  } state_e;

  state_e              state_q,     state_d;
  logic [ADDR_W-1:0]   addr_q,      addr_d;
  logic [ADDR_W:0]     count_q,     count_d;
  logic                err_q,       err_d;
  logic                out_valid_q, out_valid_d;
  logic [31:0]         out_instr_q, out_instr_d;
  logic [ADDR_W-1:0]   out_addr_q,  out_addr_d;

  logic [31:0]         packed_instr;
  logic                packed_legal;
  logic                accept;

  mips_instr_pack u_pack (
    .kind  (in_kind),
    .rs    (in_rs),
    .rt    (in_rt),
    .rd    (in_rd),
    .imm   (in_imm),
    .instr (packed_instr),
    .legal (packed_legal)
  );

  // The output register can take a new word when it is empty or being drained.
  // start wins over any acceptance in the same cycle.
  assign in_ready = (state_q == ST_RUN) && (!out_valid_q || out_ready) && !start;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    count_d     = count_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_addr_d  = out_addr_q;

    if (start) begin
      // Begin a new program. Any pending word is dropped.
      state_d     = ST_RUN;
      addr_d      = '0;
      count_d     = '0;
      err_d       = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      if (out_ready) begin
        out_valid_d = 1'b0;
      end
      if (accept) begin
        if (packed_legal) begin
          out_valid_d = 1'b1;
          out_instr_d = packed_instr;
          out_addr_d  = addr_q;
          addr_d      = addr_q + ADDR_W'(1);
          count_d     = count_q + (ADDR_W + 1)'(1);
          if (count_d == DEPTH) begin
            state_d = ST_FULL;
          end
        end else begin
          // An illegal kind is consumed silently. Only the sticky flag records it.
          err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_addr_q  <= out_addr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_addr  = out_addr_q;
  assign count     = count_q;
  assign err       = err_q;
  assign full      = (state_q == ST_FULL);

endmodule : mips_instr_encoder
`default_nettype wire

// File: tb/tb_mips_instr_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mips_instr_encoder                                           |
// | Purpose  : Self-checking bench for mips_instr_encoder (ADDR_W=2), using    |
// |            directed scenarios plus randomized stimulus against a           |
// |            behavioural reference model.                                    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_mips_instr_encoder;

  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    in_kind = '0;
  logic [4:0]    in_rs = '0, in_rt = '0, in_rd = '0;
  logic [15:0]   in_imm = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_instr;
  logic [AW-1:0] out_addr;
  logic [AW:0]   count;
  logic          err;
  logic          full;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state. m_state: 0 idle, 1 run, 2 full.
  int          m_state = 0;
  int          m_addr  = 0;
  int          m_count = 0;
  bit          m_err   = 0;
  bit          m_ov    = 0;
  logic [31:0] m_instr = '0;
  int          m_oaddr = 0;

  always #5 clk = ~clk;

  mips_instr_encoder #(.ADDR_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_kind   (in_kind),
    .in_rs     (in_rs),
    .in_rt     (in_rt),
    .in_rd     (in_rd),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .count     (count),
    .err       (err),
    .full      (full)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Encoding computed arithmetically from the field layout and the opcode/funct tables.
  function automatic logic [31:0] ref_encode(input int kind, input int rs, input int rt,
                                             input int rd, input int imm);
    longint unsigned op, fn, w;
    if (kind <= 4) begin
      case (kind)
        0: fn = 32;  1: fn = 34;  2: fn = 36;  3: fn = 37;  default: fn = 42;
      endcase
      w = longint'(rs) * 2097152 + longint'(rt) * 65536 + longint'(rd) * 2048 + fn;
    end else begin
      case (kind)
        5: op = 35;  6: op = 43;  7: op = 4;  default: op = 8;
      endcase
      w = op * 67108864 + longint'(rs) * 2097152 + longint'(rt) * 65536 + longint'(imm);
    end
    return w[31:0];
  endfunction

  task automatic drive(input bit s, input bit v, input int k, input int rs, input int rt,
                       input int rd, input int imm, input bit ordy);
    start     = s;
    in_valid  = v;
    in_kind   = 4'(k);
    in_rs     = 5'(rs);
    in_rt     = 5'(rt);
    in_rd     = 5'(rd);
    in_imm    = 16'(imm);
    out_ready = ordy;
  endtask

  task automatic model_reset();
    m_state = 0; m_addr = 0; m_count = 0; m_err = 0; m_ov = 0; m_instr = '0; m_oaddr = 0;
  endtask

  // One clock cycle. It checks in_ready before the edge, advances the model
  // at the edge, and then checks all outputs shortly after the edge.
  task automatic step();
    bit rdy_exp, acc;
    #1;
    rdy_exp = (m_state == 1) && (!m_ov || out_ready) && !start;
    check_eq("in_ready", 32'(in_ready), 32'(rdy_exp));
    acc = in_valid && rdy_exp;
    @(posedge clk);
    if (start) begin
      m_state = 1; m_addr = 0; m_count = 0; m_err = 0; m_ov = 0;
    end else begin
      if (m_ov && out_ready) m_ov = 0;
      if (acc) begin
        if (in_kind <= 8) begin
          m_ov    = 1;
          m_instr = ref_encode(int'(in_kind), int'(in_rs), int'(in_rt), int'(in_rd), int'(in_imm));
          m_oaddr = m_addr;
          m_addr  = (m_addr + 1) % DEPTH;
          m_count = m_count + 1;
          if (m_count == DEPTH) m_state = 2;
        end else begin
          m_err = 1;
        end
      end
    end
    #1;
    check_eq("out_valid", 32'(out_valid), 32'(m_ov));
    if (m_ov) begin
      check_eq("out_instr", out_instr, m_instr);
      check_eq("out_addr", 32'(out_addr), 32'(m_oaddr));
    end
    check_eq("count", 32'(count), 32'(m_count));
    check_eq("err", 32'(err), 32'(m_err));
    check_eq("full", 32'(full), 32'(m_state == 2));
    @(negedge clk);
  endtask

  task automatic idle(input bit ordy);
    drive(0, 0, 0, 0, 0, 0, 0, ordy);
  endtask

  initial begin
    // Reset values
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_instr", out_instr, 32'd0);
    check_eq("rst_out_addr", 32'(out_addr), 32'd0);
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_full", 32'(full), 32'd0);
    rst_n = 1'b1;
    idle(1); step();  // IDLE: nothing accepted

    // ADD rs=1 rt=2 rd=3
    drive(1, 0, 0, 0, 0, 0, 0, 1); step();
    drive(0, 1, 0, 1, 2, 3, 0, 1); step();
    check_eq("add_instr", out_instr, 32'h00221820);
    check_eq("add_addr", 32'(out_addr), 32'd0);
    idle(1); step();

    // LW then SW back-to-back
    drive(1, 0, 0, 0, 0, 0, 0, 1); step();
    drive(0, 1, 5, 0, 8, 0, 4, 1); step();
    check_eq("lw_instr", out_instr, 32'h8C080004);
    drive(0, 1, 6, 29, 31, 0, 8, 1); step();
    check_eq("sw_instr", out_instr, 32'hAFBF0008);
    check_eq("sw_addr", 32'(out_addr), 32'd1);
    check_eq("sw_count", 32'(count), 32'd2);
    idle(1); step();

    // BEQ stalled for three cycles, then ADDI
    drive(1, 0, 0, 0, 0, 0, 0, 1); step();
    drive(0, 1, 7, 1, 2, 0, 16'hFFFF, 0); step();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 8, 0, 9, 0, 5, 0); step();
      check_eq("beq_hold", out_instr, 32'h1022FFFF);
      check_eq("stall_in_ready", 32'(in_ready), 32'd0);
    end
    drive(0, 1, 8, 0, 9, 0, 5, 1); step();
    check_eq("addi_instr", out_instr, 32'h20090005);
    check_eq("addi_addr", 32'(out_addr), 32'd1);
    idle(1); step();

    // Illegal kind, then ADD
    drive(1, 0, 0, 0, 0, 0, 0, 1); step();
    drive(0, 1, 12, 3, 3, 3, 0, 1); step();
    check_eq("illegal_no_word", 32'(out_valid), 32'd0);
    drive(0, 1, 0, 1, 2, 3, 0, 1); step();
    check_eq("illegal_err", 32'(err), 32'd1);
    check_eq("after_illegal_addr", 32'(out_addr), 32'd0);

    // Fill memory, then restart
    drive(1, 0, 0, 0, 0, 0, 0, 1); step();
    drive(0, 1, 13, 0, 0, 0, 0, 1); step();
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 1, i, i + 1, i + 2, 0, 1); step();
      if (i < 4) check_eq("fill_addr", 32'(out_addr), 32'(i));
    end
    check_eq("fill_full", 32'(full), 32'd1);
    check_eq("fill_count", 32'(count), 32'd4);
    check_eq("fill_in_ready", 32'(in_ready), 32'd0);
    drive(1, 0, 0, 0, 0, 0, 0, 1); step();
    check_eq("restart_full", 32'(full), 32'd0);
    check_eq("restart_err", 32'(err), 32'd0);
    drive(0, 1, 2, 7, 8, 9, 0, 1); step();
    check_eq("restart_addr", 32'(out_addr), 32'd0);

    // start while a word is pending
    drive(1, 0, 0, 0, 0, 0, 0, 0); step();
    drive(0, 1, 0, 1, 2, 3, 0, 0); step();
    drive(1, 1, 1, 4, 5, 6, 0, 0); step();
    check_eq("start_drop_valid", 32'(out_valid), 32'd0);
    check_eq("start_drop_count", 32'(count), 32'd0);
    drive(0, 1, 1, 4, 5, 6, 0, 1); step();
    check_eq("after_start_instr", out_instr, 32'h00853022);
    check_eq("after_start_addr", 32'(out_addr), 32'd0);

    // Asynchronous reset while a word is pending
    drive(0, 1, 3, 1, 1, 1, 0, 0); step();
    idle(0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("async_rst_valid", 32'(out_valid), 32'd0);
    check_eq("async_rst_count", 32'(count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1); step();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      int k;
      k = ($urandom_range(0, 9) == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 8));
      drive(($urandom_range(0, 29) == 0), ($urandom_range(0, 9) < 7), k,
            int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
            int'($urandom_range(0, 65535)), ($urandom_range(0, 9) < 6));
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_mips_instr_encoder
`default_nettype wire

// File: doc/mips_instr_encoder.md
# mips_instr_encoder

Streaming MIPS instruction encoder, the producer side of the main control decoder. It takes one symbolic instruction per handshake (kind, register fields, immediate) and packs it into a 32-bit word. It emits that word with an auto-incrementing instruction-memory write address. It sits between the test/program loader and the instruction memory write port, so programs can be built in-fabric from compact descriptors.

## Interface
- ADDR_W, 6, instruction-memory address width; depth = 2^ADDR_W words
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low (one clock; reset asynchronous active-low)
- start  in  1  one-cycle pulse: begin a new program at address 0
- in_valid  in  1  descriptor valid
- in_ready  out  1  encoder can accept descriptor this cycle
- in_kind  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 LW, 6 SW, 7 BEQ, 8 ADDI; 9–15 illegal
- in_rs, in_rt, in_rd  in  5 each  register fields
- in_imm  in  16  immediate / branch offset, passed verbatim
- out_valid  out  1  encoded word valid
- out_ready  in  1  memory port accepts word
- out_instr  out  32  encoded instruction
- out_addr  out  ADDR_W  word address of out_instr
- count  out  ADDR_W+1  words accepted since start
- err  out  1  sticky: illegal kind consumed since start
- full  out  1  memory full, no further input accepted

## Operation
- R-type (kinds 0–4): {6'b000000, rs, rt, rd, 5'b0, funct}; funct ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010.
- I-type: {opcode, rs, rt, imm}; LW 100011, SW 101011, BEQ 000100, ADDI 001000. in_rd is ignored.
- FSM states:
  - IDLE (after reset): in_ready=0.
  - RUN: accepting descriptors.
  - FULL: in_ready=0; pending output still drains.
- Transitions:
  - start → RUN from any state. It clears addr, count, err, full and out_valid; a pending word is dropped.
  - RUN → FULL when an accepted legal descriptor makes count = 2^ADDR_W.
- In RUN: in_ready = !out_valid || out_ready, forced 0 in the cycle start is high.
- Acceptance is in_valid && in_ready.
- Legal kind accepted:
  - register word, out_addr = addr, out_valid=1;
  - addr wraps modulo 2^ADDR_W; count increments.
- Illegal kind accepted: descriptor consumed, nothing emitted, err=1, addr/count unchanged.
- out_valid clears on out_ready unless a new word loads in the same cycle.
- Reset values: in_ready 0, out_valid 0, out_instr 0, out_addr 0, count 0, err 0, full 0; state IDLE.
- Asynchronous reset mid-stream discards the pending word immediately.

## Timing
- Latency: descriptor accepted at edge N → out_valid with the word after edge N, visible in cycle N+1.
- Throughput: 1 word/cycle while out_ready held high.
- Output handshake: out_instr/out_addr are held stable while out_valid && !out_ready.
- in_ready is combinational from out_valid, out_ready, state and start; no combinational in_valid→out path.
- full asserts the cycle after the 2^ADDR_W-th legal acceptance.

## Structure
- Shared package mips_pkg holds:
  - kind enumeration (4-bit);
  - opcode constants R_TYPE, LW, SW, BEQ, ADDI, shared with the main decoder;
  - funct constants for the five R-type ops.
- Sub-module mips_instr_pack: purely combinational, (kind, rs, rt, rd, imm) → (instr[31:0], legal).
- Top level holds the FSM, address/count registers and the output register.

## Test plan
- Reset, start, ADD rs=1 rt=2 rd=3, out_ready=1 → out_instr 0x00221820, out_addr 0 one cycle after accept.
- LW rs=0 rt=8 imm=4, then SW rs=29 rt=31 imm=8 back-to-back → 0x8C080004 @0, 0xAFBF0008 @1; count=2.
- BEQ rs=1 rt=2 imm=0xFFFF with out_ready=0 for 3 cycles:
  - 0x1022FFFF held stable on out_instr;
  - in_ready=0 during the stall;
  - next ADDI rs=0 rt=9 imm=5 emits 0x20090005 @1.
- kind=12, then ADD → err=1, no word emitted for kind 12; ADD lands at addr 0.
- ADDR_W=2, five legal descriptors:
  - first four accepted at addrs 0–3;
  - full=1, count=4; fifth stalls with in_ready=0;
  - start → full=0, err=0, next word at addr 0.
- start asserted together with in_valid while a word is pending → pending word dropped, descriptor not accepted, accepted next cycle at addr 0.
